fpga_robots_game_sched: RTL and testbench

- Command scheduler sitting between the keyboard command decoder and the play engine.
- Latches pulsed command bits as pending requests and prioritises them.
- Waits for vertical blanking where an opcode requires it, then hands exactly one opcode at a time to the play engine over a valid/ready handshake and tracks its completion.
- Chains follow-on opcodes (NEWGAME→NEWLEVEL, level cleared→ENDLEVEL→NEWLEVEL) and tracks game-over.

---
 rtl/fpga_robots_game_sched_pkg.sv | 78 +++++++
 rtl/fpga_robots_game_prienc16.sv | 20 ++
 rtl/fpga_robots_game_sched.sv | 203 ++++++++++++++++++++
 tb/tb_fpga_robots_game_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_robots_game_sched_pkg.sv
// Shared definitions for the robots-game command scheduler and the play engine:
// opcodes, command bit positions, engine status codes and move arguments.
package fpga_robots_game_sched_pkg;

  // Opcodes handed to the play engine.
  typedef enum logic [3:0] {
    CMD_IDLE     = 4'd0,
    CMD_DUMP     = 4'd1,
    CMD_NEWGAME  = 4'd2,
    CMD_NEWLEVEL = 4'd3,
    CMD_ENDLEVEL = 4'd4,
    CMD_MOVE     = 4'd5
  } opcode_e;

  // Bit positions inside the keyboard command pulse word.
  typedef enum logic [3:0] {
    CB_N    = 4'd0,
    CB_NE   = 4'd1,
    CB_E    = 4'd2,
    CB_SE   = 4'd3,
    CB_S    = 4'd4,
    CB_SW   = 4'd5,
    CB_W    = 4'd6,
    CB_NW   = 4'd7,
    CB_STAY = 4'd8,
    CB_TELE = 4'd9,
    CB_NEW  = 4'd10,
    CB_DUMP = 4'd11
  } cmd_bit_e;

  // Status reported by the engine together with op_done.
  typedef enum logic [1:0] {
    ST_CONTINUE = 2'd0,
    ST_CLEARED  = 2'd1,
    ST_DEAD     = 2'd2,
    ST_RSVD     = 2'd3
  } status_e;

  // MOVE argument codes (equal to the command bit index that produced them).
  typedef enum logic [3:0] {
    ARG_N    = 4'd0,
    ARG_NE   = 4'd1,
    ARG_E    = 4'd2,
    ARG_SE   = 4'd3,
    ARG_S    = 4'd4,
    ARG_SW   = 4'd5,
    ARG_W    = 4'd6,
    ARG_NW   = 4'd7,
    ARG_STAY = 4'd8,
    ARG_TELE = 4'd9
  } move_arg_e;

  // Scheduler states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAITVB = 2'd1,
    S_ISSUE  = 2'd2,
    S_RUN    = 2'd3
  } sched_state_e;

  // Follow-on operation queued by a completed opcode.
  typedef enum logic [1:0] {
    CH_NONE     = 2'd0,
    CH_NEWLEVEL = 2'd1,
    CH_ENDLEVEL = 2'd2
  } chain_e;

  // Command bits that request a MOVE (directions, stay, teleport).
  localparam logic [15:0] MOVE_CMD_MASK = 16'h03FF;

  // True when the opcode has to start inside vertical blanking.
  function automatic logic op_needs_vblank(input logic [5:0] mask, input opcode_e op);
    logic [15:0] m;
    m = {10'b0, mask};
    return m[op];
  endfunction

endpackage

// File: rtl/fpga_robots_game_prienc16.sv
// Lowest-set-bit priority encoder over a 16-bit request vector.
module fpga_robots_game_prienc16 (
  input  logic [15:0] req_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Scan upward and keep the first set bit found.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (req_i[i] && !any_o) begin
        idx_o = i[3:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_robots_game_sched.sv
// Command scheduler between the keyboard decoder and the play engine.
// Latches command pulses as pending requests, picks one by priority, waits for
// vblank where needed, hands it over with valid/ready and tracks completion,
// follow-on opcodes, game-over and a watchdog on the engine.
module fpga_robots_game_sched
  import fpga_robots_game_sched_pkg::*;
#(
  parameter int unsigned     TO_W    = 17,
  parameter logic [TO_W-1:0] TIMEOUT = 17'd100000,
  parameter logic [5:0]      VB_MASK = 6'b111100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        vblank,
  output logic        op_valid,
  output logic [3:0]  op_code,
  output logic [3:0]  op_arg,
  input  logic        op_ready,
  input  logic        op_done,
  input  logic [1:0]  op_status,
  output logic        game_active,
  output logic        err
);

  sched_state_e    state_q, state_d;
  opcode_e         cur_op_q, cur_op_d;
  opcode_e         sel_op;
  chain_e          chain_q, chain_d;
  logic [3:0]      op_arg_q, op_arg_d;
  logic [3:0]      mv_arg_q, mv_arg_d;
  logic            p_new_q, p_new_d;
  logic            p_dump_q, p_dump_d;
  logic            p_move_q, p_move_d;
  logic            game_active_q, game_active_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] wd_q, wd_d;

  logic [3:0]      mv_idx;
  logic            mv_any;
  logic            mv_take;
  logic            accept;
  logic            run_done;
  logic            wd_count;
  logic            wd_expire;
  logic            st_cleared;
  logic            st_dead;

  fpga_robots_game_prienc16 u_prienc (
    .req_i (cmd & MOVE_CMD_MASK),
    .idx_o (mv_idx),
    .any_o (mv_any)
  );

  assign mv_take    = mv_any && (game_active_q || p_new_q);
  assign accept     = (state_q == S_ISSUE) && op_ready;
  assign run_done   = (state_q == S_RUN) && op_done;
  assign wd_count   = (state_q == S_RUN) && (cur_op_q != CMD_DUMP);
  // A done pulse on the expiry cycle still counts as a normal completion.
  assign wd_expire  = wd_count && (wd_q == TIMEOUT) && !op_done;
  assign st_cleared = (op_status == ST_CLEARED);
  assign st_dead    = (op_status == ST_DEAD);

  assign op_valid    = (state_q == S_ISSUE);
  assign op_code     = cur_op_q;
  assign op_arg      = op_arg_q;
  assign game_active = game_active_q;
  assign err         = err_q;

  // Priority pick among pending requests: NEWGAME > chain > DUMP > MOVE.
  always_comb begin
    sel_op = CMD_IDLE;
    if (p_new_q)                      sel_op = CMD_NEWGAME;
    else if (chain_q == CH_NEWLEVEL)  sel_op = CMD_NEWLEVEL;
    else if (chain_q == CH_ENDLEVEL)  sel_op = CMD_ENDLEVEL;
    else if (p_dump_q)                sel_op = CMD_DUMP;
    else if (p_move_q)                sel_op = CMD_MOVE;
  end

  // Pending request flags; a pulse on the accept edge re-arms the flag.
  always_comb begin
    p_new_d  = p_new_q;
    p_dump_d = p_dump_q;
    p_move_d = p_move_q;
    mv_arg_d = mv_arg_q;
    if (accept && (cur_op_q == CMD_NEWGAME)) p_new_d  = 1'b0;
    if (accept && (cur_op_q == CMD_DUMP))    p_dump_d = 1'b0;
    if (accept && (cur_op_q == CMD_MOVE))    p_move_d = 1'b0;
    if (cmd[CB_NEW])  p_new_d  = 1'b1;
    if (cmd[CB_DUMP]) p_dump_d = 1'b1;
    if (mv_take) begin
      p_move_d = 1'b1;
      mv_arg_d = mv_idx;
    end
    // Player death flushes any queued move.
    if (run_done && (cur_op_q == CMD_MOVE) && st_dead) p_move_d = 1'b0;
  end

  // Chain register, game-active tracking and sticky watchdog error.
  always_comb begin
    chain_d       = chain_q;
    game_active_d = game_active_q;
    err_d         = err_q;
    if (accept && ((cur_op_q == CMD_NEWGAME) || (cur_op_q == CMD_NEWLEVEL) ||
                   (cur_op_q == CMD_ENDLEVEL))) begin
      chain_d = CH_NONE;
    end
    if (run_done) begin
      case (cur_op_q)
        CMD_NEWGAME: begin
          chain_d       = CH_NEWLEVEL;
          game_active_d = 1'b1;
        end
        CMD_MOVE: begin
          if (st_cleared) chain_d = CH_ENDLEVEL;
          if (st_dead)    game_active_d = 1'b0;
        end
        CMD_ENDLEVEL: chain_d = CH_NEWLEVEL;
        CMD_NEWLEVEL: chain_d = CH_NONE;
        default:      chain_d = chain_q;
      endcase
    end
    if (wd_expire) begin
      chain_d = CH_NONE;
      err_d   = 1'b1;
    end
  end

  // Scheduler next state, offered opcode/argument and watchdog counter.
  always_comb begin
    state_d  = state_q;
    cur_op_d = cur_op_q;
    op_arg_d = op_arg_q;
    wd_d     = wd_q;
    unique case (state_q)
      S_IDLE: begin
        cur_op_d = sel_op;
        op_arg_d = '0;
        if (sel_op != CMD_IDLE) begin
          if (op_needs_vblank(VB_MASK, sel_op)) begin
            state_d = S_WAITVB;
          end else begin
            state_d = S_ISSUE;
            if (sel_op == CMD_MOVE) op_arg_d = mv_arg_d;
          end
        end
      end
      S_WAITVB: begin
        if (vblank) begin
          state_d = S_ISSUE;
          // Argument frozen here so the latest move before vblank is the one sent.
          if (cur_op_q == CMD_MOVE) op_arg_d = mv_arg_d;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          state_d = S_RUN;
          wd_d    = '0;
        end
      end
      S_RUN: begin
        if (op_done || wd_expire) begin
          state_d  = S_IDLE;
          cur_op_d = CMD_IDLE;
          op_arg_d = '0;
        end else if (wd_count && (wd_q != TIMEOUT)) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_op_q      <= CMD_IDLE;
      chain_q       <= CH_NONE;
      op_arg_q      <= '0;
      mv_arg_q      <= '0;
      p_new_q       <= 1'b0;
      p_dump_q      <= 1'b0;
      p_move_q      <= 1'b0;
      game_active_q <= 1'b0;
      err_q         <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      cur_op_q      <= cur_op_d;
      chain_q       <= chain_d;
      op_arg_q      <= op_arg_d;
      mv_arg_q      <= mv_arg_d;
      p_new_q       <= p_new_d;
      p_dump_q      <= p_dump_d;
      p_move_q      <= p_move_d;
      game_active_q <= game_active_d;
      err_q         <= err_d;
      wd_q          <= wd_d;
    end
  end

endmodule

// File: tb/tb_fpga_robots_game_sched.sv
// Testbench for the robots-game command scheduler: directed steps followed by
// randomized command words, checked against a transaction-level model.
module tb_fpga_robots_game_sched;

  localparam int unsigned TB_TO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = '0;
  logic        vblank = 1'b0;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [3:0]  op_arg;
  logic        op_ready = 1'b0;
  logic        op_done = 1'b0;
  logic [1:0]  op_status = '0;
  logic        game_active;
  logic        err;

  always #5 clk = ~clk;

  fpga_robots_game_sched #(
    .TO_W    (17),
    .TIMEOUT (17'd300),
    .VB_MASK (6'b111100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .vblank      (vblank),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .op_arg      (op_arg),
    .op_ready    (op_ready),
    .op_done     (op_done),
    .op_status   (op_status),
    .game_active (game_active),
    .err         (err)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Model: pending requests as plain flags, chain as the opcode it will issue.
  bit m_new, m_dump, m_move, m_active, m_err;
  int m_arg, m_chain;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_new = 0; m_dump = 0; m_move = 0; m_active = 0; m_err = 0;
    m_arg = 0; m_chain = 0;
  endfunction

  function automatic int m_pick();
    if (m_new)        return 2;
    if (m_chain != 0) return m_chain;
    if (m_dump)       return 1;
    if (m_move)       return 5;
    return 0;
  endfunction

  function automatic void m_cmd(input logic [15:0] w);
    if (w[9:0] != '0 && (m_active || m_new)) begin
      m_move = 1;
      for (int i = 9; i >= 0; i--) if (w[i]) m_arg = i;
    end
    if (w[10]) m_new = 1;
    if (w[11]) m_dump = 1;
  endfunction

  function automatic void m_accept(input int op);
    case (op)
      1: m_dump = 0;
      2: begin m_new = 0; m_chain = 0; end
      3, 4: m_chain = 0;
      5: m_move = 0;
      default: ;
    endcase
  endfunction

  function automatic void m_done(input int op, input int st);
    case (op)
      2: begin m_chain = 3; m_active = 1; end
      3: m_chain = 0;
      4: m_chain = 3;
      5: begin
        if (st == 1) m_chain = 4;
        if (st == 2) begin m_active = 0; m_move = 0; end
      end
      default: ;
    endcase
  endfunction

  task automatic inject(input logic [15:0] w);
    cmd = w;
    step();
    cmd = '0;
    m_cmd(w);
  endtask

  // From an idle scheduler with something pending: select, wait, offer, accept.
  task automatic issue_op(input int vb_wait, input logic [15:0] extra,
                          input logic [15:0] acc_cmd, output int op);
    int exp_op;
    int rd;
    exp_op = m_pick();
    step();
    if (exp_op == 1) begin
      chk("dump_t2_valid", op_valid, 1);
    end else begin
      chk("waitvb_valid", op_valid, 0);
      for (int i = 0; i < vb_wait; i++) begin
        if (i == 0 && extra != '0) begin cmd = extra; m_cmd(extra); end
        if (i == vb_wait - 1) begin op_done = 1'b1; op_status = 2'd1; end
        step();
        cmd = '0; op_done = 1'b0; op_status = '0;
      end
      chk("pre_vb_valid", op_valid, 0);
      vblank = 1'b1;
      step();
      vblank = 1'b0;
      chk("vb_plus1_valid", op_valid, 1);
    end
    chk("op_code", op_code, exp_op);
    chk("op_arg", op_arg, (exp_op == 5) ? m_arg : 0);
    rd = $urandom_range(0, 2);
    for (int i = 0; i < rd; i++) begin
      step();
      chk("hold_valid", op_valid, 1);
      chk("hold_code", op_code, exp_op);
    end
    op_ready = 1'b1; cmd = acc_cmd;
    step();
    op_ready = 1'b0; cmd = '0;
    m_accept(exp_op);
    m_cmd(acc_cmd);
    chk("run_valid", op_valid, 0);
    op = exp_op;
  endtask

  task automatic finish_op(input int op, input int hold, input int st);
    for (int i = 0; i < hold; i++) begin
      vblank = (i % 3 == 1);
      step();
      vblank = 1'b0;
    end
    chk("run_hold_valid", op_valid, 0);
    op_done = 1'b1; op_status = 2'(st);
    step();
    op_done = 1'b0; op_status = '0;
    m_done(op, st);
    chk("game_active", game_active, m_active);
    chk("err", err, m_err);
  endtask

  task automatic idle_chk();
    for (int i = 0; i < 4; i++) begin
      vblank = (i == 1);
      step();
      vblank = 1'b0;
      chk("idle_no_op", op_valid, 0);
    end
  endtask

  task automatic drain(input bit rnd);
    int op, p, vbw, st, hold, k;
    logic [15:0] extra, acc;
    k = 0;
    while (m_pick() != 0 && k < 12) begin
      p = m_pick();
      vbw = 2; extra = '0; acc = '0; st = 0; hold = 1;
      if (rnd) begin
        vbw  = $urandom_range(1, 4);
        st   = $urandom_range(0, 3);
        hold = $urandom_range(0, 4);
        if (p == 5 && $urandom_range(0, 2) == 0) extra = 16'($urandom_range(1, 1023));
        if (p == 1 && $urandom_range(0, 3) == 0) acc = 16'h0800;
        if (p == 5 && $urandom_range(0, 3) == 0) acc = 16'($urandom_range(1, 1023));
      end
      issue_op(vbw, extra, acc, op);
      finish_op(op, hold, st);
      k++;
    end
    idle_chk();
  endtask

  initial begin
    int op;
    logic [15:0] w;
    m_reset();
    step(); step();
    rst = 1'b0;
    chk("rst_valid", op_valid, 0);
    chk("rst_code", op_code, 0);
    chk("rst_arg", op_arg, 0);
    chk("rst_active", game_active, 0);
    chk("rst_err", err, 0);

    // New game waits 50 cycles for vblank, then NEWLEVEL follows.
    inject(16'h0400);
    issue_op(50, '0, '0, op);
    finish_op(op, 3, 0);
    chk("ng_active", game_active, 1);
    drain(0);

    // Lowest direction wins; a later pulse before issue replaces it.
    inject(16'h0024);
    drain(0);
    inject(16'h0024);
    issue_op(3, 16'h0080, '0, op);
    chk("latest_arg", op_arg, 7);
    finish_op(op, 2, 0);
    drain(0);

    // DUMP needs no vblank and precedes the MOVE; re-pulse on accept edge.
    inject(16'h0808);
    drain(0);
    inject(16'h0800);
    issue_op(0, '0, 16'h0800, op);
    finish_op(op, 1, 0);
    drain(0);

    // Level cleared chains ENDLEVEL then NEWLEVEL; death ends the game.
    inject(16'h0002);
    issue_op(2, '0, '0, op);
    finish_op(op, 1, 1);
    drain(0);
    inject(16'h0010);
    issue_op(2, '0, '0, op);
    finish_op(op, 1, 2);
    chk("dead_active", game_active, 0);
    inject(16'h0001);
    idle_chk();
    op_done = 1'b1; op_status = 2'd1;
    step();
    op_done = 1'b0; op_status = '0;
    idle_chk();

    // Long DUMP never trips the watchdog.
    inject(16'h0400);
    drain(0);
    inject(16'h0800);
    issue_op(0, '0, '0, op);
    finish_op(op, 2 * TB_TO + 10, 0);
    drain(0);

    // Stalled MOVE trips the watchdog; the scheduler keeps serving.
    inject(16'h0040);
    issue_op(2, '0, '0, op);
    for (int i = 0; i < TB_TO - 2; i++) step();
    chk("wd_early_err", err, 0);
    begin
      int n;
      n = 0;
      while (err !== 1'b1 && n < 8) begin step(); n++; end
    end
    chk("wd_err", err, 1);
    chk("wd_idle_valid", op_valid, 0);
    m_err = 1; m_chain = 0;
    op_done = 1'b1; op_status = 2'd1;
    step();
    op_done = 1'b0; op_status = '0;
    inject(16'h0800);
    drain(0);

    // Reset while running with a DUMP pending clears everything.
    inject(16'h0800);
    issue_op(0, '0, '0, op);
    cmd = 16'h0800;
    step();
    cmd = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_reset();
    chk("rrst_valid", op_valid, 0);
    chk("rrst_code", op_code, 0);
    chk("rrst_arg", op_arg, 0);
    chk("rrst_active", game_active, 0);
    chk("rrst_err", err, 0);
    idle_chk();
    idle_chk();

    // Randomized command words.
    inject(16'h0400);
    drain(1);
    for (int it = 0; it < 40; it++) begin
      w = '0;
      if ($urandom_range(0, 3) != 0) w[9:0] = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 5) == 0) w[10] = 1'b1;
      if ($urandom_range(0, 2) == 0) w[11] = 1'b1;
      w[15:12] = 4'($urandom_range(0, 15));
      inject(w);
      drain(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
